// File: rtl/usb_auth_msg_switch.sv
// usb_auth_msg_switch: host<->responder switch for USB Type-C auth messages.
// Forward: host msg -> one of N_CH channels with ack timeout and bounded retry.
// Return: per-channel replies merged to the host by round-robin arbitration.
// Ports: clk, reset (sync, active-low); host side h_req/h_dest/h_msg,
//   h_busy/h_done/h_err, h_resp_valid/h_resp_msg/h_resp_src/h_resp_ack;
//   responder side r_req_out/r_msg_out/r_ack_in,
//   r_resp_req/r_resp_msg/r_resp_ack.
module usb_auth_msg_switch #(
  parameter int MSG_LEN   = 64,
  parameter int N_CH      = 4,
  parameter int CH_W      = 2,
  parameter int TIMEOUT   = 255,
  parameter int MAX_RETRY = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   h_req,
  input  logic [CH_W-1:0]        h_dest,
  input  logic [MSG_LEN-1:0]     h_msg,
  output logic                   h_busy,
  output logic                   h_done,
  output logic                   h_err,
  output logic [N_CH-1:0]        r_req_out,
  output logic [MSG_LEN-1:0]     r_msg_out,
  input  logic [N_CH-1:0]        r_ack_in,
  input  logic [N_CH-1:0]        r_resp_req,
  input  logic [N_CH*MSG_LEN-1:0] r_resp_msg,
  output logic [N_CH-1:0]        r_resp_ack,
  output logic                   h_resp_valid,
  output logic [MSG_LEN-1:0]     h_resp_msg,
  output logic [CH_W-1:0]        h_resp_src,
  input  logic                   h_resp_ack
);

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    GAP,
    DONE,
    ERR
  } state_t;

  state_t          state;
  logic [CH_W-1:0] dest_q;
  logic [15:0]     timer;
  logic [15:0]     retry;

  logic            bad_dest;
  logic            timed_out;
  logic            last_try;

  assign bad_dest  = int'(h_dest) >= N_CH;
  assign timed_out = timer == 16'(TIMEOUT);
  assign last_try  = retry == 16'(MAX_RETRY);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      dest_q    <= '0;
      timer     <= '0;
      retry     <= '0;
      h_busy    <= 1'b0;
      h_done    <= 1'b0;
      h_err     <= 1'b0;
      r_req_out <= '0;
      r_msg_out <= '0;
    end else begin
      h_done <= 1'b0;
      h_err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (h_req) begin
            r_msg_out <= h_msg;
            dest_q    <= h_dest;
            h_busy    <= 1'b1;
            timer     <= '0;
            if (bad_dest) begin
              state <= ERR;
              h_err <= 1'b1;
            end else begin
              state     <= SEND;
              r_req_out <= N_CH'(1) << h_dest;
            end
          end
        end
        SEND: begin
          // an ack in the timeout cycle still counts as success
          if (r_ack_in[dest_q]) begin
            state     <= DONE;
            h_done    <= 1'b1;
            r_req_out <= '0;
            timer     <= '0;
          end else if (timed_out) begin
            r_req_out <= '0;
            timer     <= '0;
            if (last_try) begin
              state <= ERR;
              h_err <= 1'b1;
            end else begin
              state <= GAP;
              retry <= retry + 16'd1;
            end
          end else begin
            timer <= timer + 16'd1;
          end
        end
        GAP: begin
          state     <= SEND;
          timer     <= '0;
          r_req_out <= N_CH'(1) << dest_q;
        end
        DONE, ERR: begin
          state  <= IDLE;
          h_busy <= 1'b0;
          retry  <= '0;
        end
        default: begin
          state     <= IDLE;
          h_busy    <= 1'b0;
          r_req_out <= '0;
        end
      endcase
    end
  end

  logic [CH_W-1:0] rr_ptr;
  logic            gnt_found;
  logic [CH_W-1:0] gnt_idx;
  int              cand;
  int              gnt_int;

  // first requester strictly after rr_ptr, wrapping around
  always_comb begin
    gnt_found = 1'b0;
    gnt_int   = 0;
    cand      = 0;
    for (int i = 1; i <= N_CH; i++) begin
      cand = int'(rr_ptr) + i;
      if (cand >= N_CH) cand = cand - N_CH;
      if (!gnt_found && r_resp_req[cand]) begin
        gnt_found = 1'b1;
        gnt_int   = cand;
      end
    end
    gnt_idx = CH_W'(gnt_int);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr       <= CH_W'(N_CH - 1);
      r_resp_ack   <= '0;
      h_resp_valid <= 1'b0;
      h_resp_msg   <= '0;
      h_resp_src   <= '0;
    end else begin
      r_resp_ack <= '0;
      if (h_resp_valid) begin
        if (h_resp_ack) h_resp_valid <= 1'b0;
      end else if (gnt_found) begin
        r_resp_ack   <= N_CH'(1) << gnt_idx;
        h_resp_msg   <= r_resp_msg[gnt_int*MSG_LEN +: MSG_LEN];
        h_resp_src   <= gnt_idx;
        rr_ptr       <= gnt_idx;
        h_resp_valid <= 1'b1;
      end
    end
  end

endmodule
